// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light controller: counter width, phase
// durations in ticks, and the phase enumeration.
package traffic_pkg;

  localparam int unsigned CNT_W = 7;

  localparam int unsigned RED_TICKS    = 10;
  localparam int unsigned GREEN_TICKS  = 7;
  localparam int unsigned YELLOW_TICKS = 3;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2
  } phase_e;

  function automatic logic [CNT_W-1:0] phase_limit(input phase_e phase);
    logic [CNT_W-1:0] lim;
    lim = '0;
    unique case (phase)
      RED:     lim = CNT_W'(RED_TICKS);
      GREEN:   lim = CNT_W'(GREEN_TICKS);
      YELLOW:  lim = CNT_W'(YELLOW_TICKS);
      default: lim = '0;
    endcase
    return lim;
  endfunction

endpackage

// File: rtl/count_down_counter_if.sv
// Control/status bundle of the per-phase down-counter. The master drives the
// tick and start value; the slave (counter) returns the count and flags.
interface count_down_counter_if
  import traffic_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_W
) ();

  logic             i_enable;
  logic [WIDTH-1:0] i_limit;
  logic [WIDTH-1:0] o_value;
  logic             o_zero;
  logic             o_done;

  modport master (
    output i_enable,
    output i_limit,
    input  o_value,
    input  o_zero,
    input  o_done
  );

  modport slave (
    input  i_enable,
    input  i_limit,
    output o_value,
    output o_zero,
    output o_done
  );

endinterface

// File: rtl/count_down_counter.sv
// Loadable down-counter: preloads i_limit on reset, decrements once per tick to 0.
// COUNTDOWN_AUTORELOAD_EN: reload i_limit on a tick at 0 instead of saturating.
module count_down_counter
  import traffic_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_W
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  count_down_counter_if.slave  bus
);

  logic [WIDTH-1:0] value_q;
  logic             done_q;
  logic [WIDTH-1:0] value_d;
  logic             done_d;
  logic             is_zero;

  always_comb begin
    is_zero = (value_q == '0);
    value_d = value_q;
    done_d  = 1'b0;
    if (bus.i_enable) begin
      if (!is_zero) begin
        value_d = value_q - WIDTH'(1);
        done_d  = (value_q == WIDTH'(1));
      end else begin
`ifdef COUNTDOWN_AUTORELOAD_EN
        value_d = bus.i_limit;
`else
        value_d = '0;
`endif
      end
    end
  end

  // Reset doubles as the preload, so it also takes priority over a tick.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      value_q <= bus.i_limit;
      done_q  <= 1'b0;
    end else begin
      value_q <= value_d;
      done_q  <= done_d;
    end
  end

  assign bus.o_value = value_q;
  assign bus.o_zero  = is_zero;
  assign bus.o_done  = done_q;

endmodule

// File: tb/tb_count_down_counter.sv
// Scoreboard bench for count_down_counter; expectations follow the build's
// COUNTDOWN_AUTORELOAD_EN setting.
module tb_count_down_counter;

  localparam int unsigned W = 7;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  count_down_counter_if #(.WIDTH(W)) bus ();

  count_down_counter #(.WIDTH(W)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  typedef struct {
    logic [W-1:0] v;
    logic         z;
    logic         d;
    string        name;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // One expected entry per driven cycle; the monitor checks it after the edge.
  task automatic step(input logic r, input logic en, input int lim,
                      input int ev, input logic ed, input string name);
    exp_t e;
    @(negedge clk);
    rst          = r;
    bus.i_enable = en;
    bus.i_limit  = W'(lim);
    e.v    = W'(ev);
    e.z    = (ev == 0);
    e.d    = ed;
    e.name = name;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (bus.o_value !== e.v) begin
          n_bad++;
          $display("FAIL %s value: got %0d expected %0d @%0t", e.name, bus.o_value, e.v, $time);
        end
        n_cmp++;
        if (bus.o_zero !== e.z) begin
          n_bad++;
          $display("FAIL %s zero: got %b expected %b @%0t", e.name, bus.o_zero, e.z, $time);
        end
        n_cmp++;
        if (bus.o_done !== e.d) begin
          n_bad++;
          $display("FAIL %s done: got %b expected %b @%0t", e.name, bus.o_done, e.d, $time);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

`ifdef COUNTDOWN_AUTORELOAD_EN
  int ar_v [8] = '{2, 1, 0, 3, 2, 1, 0, 3};
  int ar_d [8] = '{0, 0, 1, 0, 0, 0, 1, 0};
`else
  int ar_v [8] = '{2, 1, 0, 0, 0, 0, 0, 0};
  int ar_d [8] = '{0, 0, 1, 0, 0, 0, 0, 0};
`endif

  initial begin : stim
    int drain;
    bus.i_enable = 1'b0;
    bus.i_limit  = '0;

    // Reset preload
    step(1, 0, 10, 10, 0, "rst_preload");
    step(0, 0, 10, 10, 0, "rst_hold");

    // Countdown 10 -> 0, ticks 5 clocks apart
    for (int i = 1; i <= 10; i++) begin
      step(0, 1, 10, 10 - i, (i == 10), "countdown_tick");
      for (int k = 0; k < 4; k++)
        step(0, 0, 10, 10 - i, 0, "countdown_hold");
    end

`ifdef COUNTDOWN_AUTORELOAD_EN
    step(0, 1, 10, 10, 0, "reload_at_zero");
    step(0, 1, 10, 9, 0, "reload_then_tick");
`else
    for (int i = 0; i < 3; i++)
      step(0, 1, 10, 0, 0, "saturate");
`endif

    // Limit 3, eight back-to-back ticks
    step(1, 0, 3, 3, 0, "lim3_reset");
    for (int i = 0; i < 8; i++)
      step(0, 1, 3, ar_v[i], ar_d[i][0], "lim3_tick");

    // Reset mid-count with simultaneous tick
    step(1, 0, 7, 7, 0, "mid_reset_pre");
    for (int i = 1; i <= 3; i++)
      step(0, 1, 7, 7 - i, 0, "mid_count");
    step(1, 1, 7, 7, 0, "mid_reset_with_tick");
    step(0, 1, 7, 6, 0, "mid_after_reset");

    // Limit 0 at reset
    step(1, 0, 0, 0, 0, "lim0_reset");
    step(0, 0, 0, 0, 0, "lim0_hold");
    step(0, 1, 0, 0, 0, "lim0_tick");

    // Limit change mid-count is ignored until the next reset
    step(1, 0, 7, 7, 0, "limchg_reset");
    step(0, 1, 7, 6, 0, "limchg_tick1");
    step(0, 1, 3, 5, 0, "limchg_tick2");
    step(0, 0, 3, 5, 0, "limchg_hold");
    step(0, 1, 3, 4, 0, "limchg_tick3");
    step(1, 0, 3, 3, 0, "limchg_reload");
    step(0, 0, 3, 3, 0, "limchg_final");

    drain = 0;
    while (exp_q.size() > 0 && drain < 20) begin
      @(posedge clk);
      drain++;
    end
    #2;
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
